// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Build option: FETCH_HALT_DETECT_EN enables halt-opcode detection.
package inst_fetch_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [INST_W-1:0] HALT_OPCODE_DEF = 8'b0111_1000;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 3'd0;
  localparam fetch_state_t S_REQ  = 3'd1;
  localparam fetch_state_t S_RESP = 3'd2;
  localparam fetch_state_t S_HOLD = 3'd3;
  localparam fetch_state_t S_HALT = 3'd4;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_pc_reg.sv
// Program counter register: reset load, redirect load, wrapping increment.
// Redirect takes priority over increment.
module fetch_pc_reg
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_PC;
    else if (i_load)
      r_pc <= i_load_addr;
    else if (i_inc)
      r_pc <= r_pc + 1'b1;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch FSM with one outstanding read and a held output buffer.
// Build option: FETCH_HALT_DETECT_EN stops fetch after a HALT_OPCODE.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
  parameter logic [INST_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_pend;
  logic              w_pend_nxt;
  logic              r_valid;
  logic [INST_W-1:0] r_data;
  logic [ADDR_W-1:0] r_ipc;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] w_pc;
  logic              w_redir;
  logic              w_accept;
  logic              w_capture;
  logic              w_halt_op;

`ifdef FETCH_HALT_DETECT_EN
  assign w_halt_op = (mem_rdata == HALT_OPCODE);
`else
  logic w_unused_halt_op;
  assign w_unused_halt_op = &{1'b0, HALT_OPCODE};
  assign w_halt_op = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend | halt_req;
    w_redir     = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (halt_req) begin
          w_state_nxt = S_HALT;
          w_pend_nxt  = 1'b0;
        end else if (start) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ, S_RESP, S_HOLD: begin
        if (redirect_valid) begin
          // A same-cycle halt request survives the flush.
          w_redir     = 1'b1;
          w_state_nxt = S_REQ;
          w_pend_nxt  = halt_req;
        end else if (r_state == S_REQ) begin
          w_state_nxt = S_RESP;
        end else if (r_state == S_RESP) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
          w_pend_nxt  = r_pend | halt_req | w_halt_op;
        end else if (inst_ready) begin
          w_accept = 1'b1;
          if (r_pend | halt_req) begin
            w_state_nxt = S_HALT;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HALT: begin
        w_pend_nxt = 1'b0;
        if (start && !halt_req)
          w_state_nxt = S_REQ;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_accept),
    .i_load      (w_redir),
    .i_load_addr (redirect_addr),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ipc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_valid <= (w_state_nxt == S_HOLD);
      if (w_capture) begin
        r_data <= mem_rdata;
        r_ipc  <= w_pc;
      end
      if (w_accept && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mem_rd_en   = (r_state == S_REQ);
  assign mem_addr    = mem_rd_en ? w_pc : '0;
  assign inst_valid  = r_valid;
  assign inst_data   = r_data;
  assign inst_pc     = r_ipc;
  assign halted      = (r_state == S_HALT);
  assign fetch_count = r_cnt;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl.
// Covers fetch, stall, redirect, wrap, halt and reset scenarios.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic [7:0]  inst_data;
  logic [7:0]  inst_pc;
  logic        inst_ready;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0] mem [256];
  int checks;
  int errors;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: inst_valid=%b want 1", tag, inst_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    checks++; if (inst_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", inst_data); end
    checks++; if (inst_pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", inst_pc); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", mem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
    tick();
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en: got %b want 0", mem_rd_en); end
  endtask

  task automatic test_basic_fetch();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h28;
    exp_d[1] = 8'h08;
    exp_d[2] = 8'h60;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL lat_rd_en: got %b want 1", mem_rd_en); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL lat_addr: got %h want 00", mem_addr); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", inst_valid); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL lat_one_rd: got %b want 0", mem_rd_en); end
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", inst_valid); end
    for (int i = 0; i < 3; i++) begin
      wait_valid("basic");
      checks++; if (inst_data !== exp_d[i]) begin errors++; $display("FAIL basic_data%0d: got %h want %h", i, inst_data, exp_d[i]); end
      checks++; if (inst_pc !== 8'(i)) begin errors++; $display("FAIL basic_pc%0d: got %h want %h", i, inst_pc, 8'(i)); end
      tick();
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_clr%0d: got %b want 0", i, inst_valid); end
    end
    inst_ready = 1'b0;
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_data !== 8'hA5 || inst_pc !== 8'h03) begin
        errors++;
        $display("FAIL stall_hold%0d: v=%b d=%h pc=%h want 1 a5 03", i, inst_valid, inst_data, inst_pc);
      end
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en%0d: got %b want 0", i, mem_rd_en); end
      checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL stall_count%0d: got %0d want 3", i, fetch_count); end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL stall_accept: got %0d want 4", fetch_count); end
  endtask

  task automatic test_redirect();
    wait_valid("redir_a");
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_valid("redir_b");
    checks++; if (inst_pc !== 8'h05) begin errors++; $display("FAIL redir_pc5: got %h want 05", inst_pc); end
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 8'h40;
    tick();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", inst_valid); end
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h40) begin errors++; $display("FAIL redir_addr: rd=%b addr=%h want 1 40", mem_rd_en, mem_addr); end
    checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL redir_count: got %0d want 5", fetch_count); end
    wait_valid("redir_c");
    checks++; if (inst_pc !== 8'h40 || inst_data !== mem[8'h40]) begin errors++; $display("FAIL redir_inst: pc=%h d=%h want 40 %h", inst_pc, inst_data, mem[8'h40]); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_addr = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h want ff", mem_addr); end
    wait_valid("wrap");
    checks++; if (inst_pc !== 8'hFF) begin errors++; $display("FAIL wrap_pc: got %h want ff", inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_next: rd=%b addr=%h want 1 00", mem_rd_en, mem_addr); end
    checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL wrap_count: got %0d want 6", fetch_count); end
  endtask

  task automatic test_halt_req();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hreq_early: got %b want 0", halted); end
    wait_valid("hreq");
    checks++; if (inst_pc !== 8'h00) begin errors++; $display("FAIL hreq_pc: got %h want 00", inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hreq_halted: got %b want 1", halted); end
    checks++; if (fetch_count !== 16'd7) begin errors++; $display("FAIL hreq_count: got %0d want 7", fetch_count); end
    tick();
    tick();
    checks++; if (mem_rd_en !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL hreq_quiet: rd=%b v=%b want 0 0", mem_rd_en, inst_valid); end
    start = 1'b1;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hreq_both: got %b want 1", halted); end
    tick();
    start = 1'b0;
    checks++; if (halted !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 8'h01) begin
      errors++;
      $display("FAIL hreq_resume: h=%b rd=%b addr=%h want 0 1 01", halted, mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_halt_opcode();
    redirect_valid = 1'b1;
    redirect_addr = 8'h07;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_addr !== 8'h07) begin errors++; $display("FAIL hop_addr: got %h want 07", mem_addr); end
    wait_valid("hop");
    checks++; if (inst_data !== 8'h78 || inst_pc !== 8'h07) begin errors++; $display("FAIL hop_inst: d=%h pc=%h want 78 07", inst_data, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hop_halted: got %b want 1", halted); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL hop_quiet%0d: got %b want 0", i, mem_rd_en); end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
`endif
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hop_run: got %b want 0", halted); end
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h08) begin errors++; $display("FAIL hop_next: rd=%b addr=%h want 1 08", mem_rd_en, mem_addr); end
  endtask

  task automatic test_reset_mid();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL mrst_out: v=%b rd=%b want 0 0", inst_valid, mem_rd_en); end
    checks++; if (fetch_count !== 16'd0 || halted !== 1'b0) begin errors++; $display("FAIL mrst_state: cnt=%0d h=%b want 0 0", fetch_count, halted); end
    tick();
    checks++; if (inst_valid !== 1'b0 || inst_data !== 8'h00) begin errors++; $display("FAIL mrst_stale: v=%b d=%h want 0 00", inst_valid, inst_data); end
    redirect_valid = 1'b1;
    redirect_addr = 8'h33;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL idle_redir: got %b want 0", mem_rd_en); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL mrst_pc: rd=%b addr=%h want 1 00", mem_rd_en, mem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;
    inst_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[0] = 8'h28;
    mem[1] = 8'h08;
    mem[2] = 8'h60;
    mem[3] = 8'hA5;
    mem[7] = 8'h78;
    mem[8] = 8'h11;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt_req();
    test_halt_opcode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC loaded by reset.
REQ-002 Parameter HALT_OPCODE, default 8'b0111_1000: opcode recognised as halt when halt detection is compiled in.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  leave IDLE/HALT and begin fetching at current PC.
REQ-006 halt_req  input  1  request stop at next instruction boundary.
REQ-007 redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 redirect_addr  input  8  redirect target PC.
REQ-009 mem_rd_en  output  1  instruction-memory read strobe.
REQ-010 mem_addr  output  8  instruction-memory address.
REQ-011 mem_rdata  input  8  read data, valid exactly one cycle after mem_rd_en.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_data  output  8  fetched instruction.
REQ-014 inst_pc  output  8  address of inst_data.
REQ-015 inst_ready  input  1  decode accepts; transfer when inst_valid && inst_ready.
REQ-016 halted  output  1  high in HALT state.
REQ-017 fetch_count  output  16  accepted-instruction count, saturating at 16'hFFFF.

Function
REQ-018 FSM states SHALL be IDLE, REQ, RESP, HOLD, HALT.
REQ-019 IDLE: start=1 -> REQ; otherwise stay; mem_rd_en=0, inst_valid=0.
REQ-020 REQ: mem_rd_en=1, mem_addr=pc for exactly one cycle -> RESP.
REQ-021 RESP: register mem_rdata into inst_data and pc into inst_pc, set inst_valid -> HOLD.
REQ-022 Latency: start sampled at edge N -> mem_rd_en high in cycle N+1 -> inst_valid high in cycle N+3.
REQ-023 HOLD: inst_valid, inst_data, inst_pc SHALL remain stable until handshake.
REQ-024 HOLD handshake: pc <= pc+1 modulo 256 (8'hFF wraps to 8'h00), fetch_count increments, inst_valid cleared next cycle, -> REQ (or HALT per REQ-027).
REQ-025 redirect_valid in REQ, RESP or HOLD: pc <= redirect_addr, in-flight/held instruction discarded (no handshake, no count), inst_valid low next cycle, -> REQ.
REQ-026 Redirect SHALL win over a simultaneous handshake and over halt_req; ignored in IDLE and HALT.
REQ-027 halt_req is latched into a pending flag; pending halt takes effect at the next handshake (-> HALT after pc increment); in IDLE, halt_req -> HALT directly.
REQ-028 HALT: halted=1, mem_rd_en=0, inst_valid=0; start=1 -> REQ at current pc, clears pending halt; start and halt_req both high in HALT -> stay HALT.
REQ-029 Redirect clears pending halt only if halt_req is not asserted in the same cycle.
REQ-030 At most one memory read SHALL be outstanding at any time.

Reset
REQ-031 reset SHALL force state=IDLE, pc=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, mem_rd_en=0, mem_addr=0, halted=0, fetch_count=0, pending halt cleared, from any state including mid-fetch.
REQ-032 A memory response arriving the cycle after reset SHALL be ignored.

Configuration
REQ-033 Macro FETCH_HALT_DETECT_EN defined: in RESP, mem_rdata==HALT_OPCODE sets pending halt, so after that instruction's handshake the FSM enters HALT.
REQ-034 Macro undefined: HALT_OPCODE SHALL have no effect; it is fetched as an ordinary instruction.

Structure
REQ-035 Shared package SHALL hold the FSM state enum, 8-bit address/instruction widths and the HALT_OPCODE default.
REQ-036 Sub-module fetch_pc_reg (PC register with increment/wrap/redirect/reset load) is natural; FSM and output buffer stay in the top.

Verification
REQ-037 Reset, start, inst_ready=1, memory holding 8'h28,8'h08,8'h60 at 0..2 -> inst_data 8'h28,8'h08,8'h60 with inst_pc 0,1,2; first inst_valid 3 cycles after start; fetch_count=3.
REQ-038 inst_ready=0 for 5 cycles in HOLD -> inst_data/inst_pc stable, no mem_rd_en, fetch_count unchanged.
REQ-039 redirect_valid with redirect_addr=8'h40 coinciding with handshake at pc=5 -> next mem_addr 8'h40, fetch_count not incremented.
REQ-040 pc=8'hFF accepted -> next mem_addr 8'h00.
REQ-041 FETCH_HALT_DETECT_EN defined, 8'b0111_1000 at address 7 -> delivered once, then halted=1, no further mem_rd_en; start resumes at address 8.
REQ-042 reset asserted in RESP -> next cycle state IDLE, inst_valid=0, pc=RESET_PC, stale mem_rdata not delivered.
